// File: rtl/mm_pkg.sv
// Shared types and constants for the main-memory back end.
package mm_pkg;

   localparam int unsigned BLK_OFF_W = 6;
   localparam logic [63:0] MM_INIT_PATTERN = 64'hDEADBEEFCAFEBABE;

   typedef enum logic [1:0] {
      StIdle,
      StFwd,
      StRead,
      StDrain
   } mm_state_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/main_memory_ctrl_if.sv
// Request/response bus between the cache controller and the main-memory back end.
interface main_memory_ctrl_if #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned WB_DEPTH = 4
) ();

   localparam int unsigned CNT_W = $clog2(WB_DEPTH) + 1;

   logic              req_valid;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              mm_ready;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic [CNT_W-1:0]  wb_count;
   logic              busy;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  mm_ready, resp_valid, resp_rdata, wb_count, busy
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output mm_ready, resp_valid, resp_rdata, wb_count, busy
   );

endinterface

// File: rtl/wb_fifo.sv
// Write-back buffer: circular FIFO of (block address, data) with newest-match lookup.
module wb_fifo #(
   parameter int unsigned BLK_W  = 26,
   parameter int unsigned IDX_W  = 10,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [BLK_W-1:0]  push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [IDX_W-1:0]  head_idx,
   output logic [DATA_W-1:0] head_data,
   output logic [CNT_W-1:0]  count,
   input  logic [BLK_W-1:0]  lookup_addr,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data
);

   logic [BLK_W-1:0]  addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q;

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + 1'b1;
         if (pop)  head_q <= head_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage; validity is tracked by count_q, so no reset needed
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= push_addr;
         data_q[tail_q] <= push_data;
      end
   end

   // Walk oldest to newest so the last match (newest) wins
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count_q) &&
             (addr_q[PTR_W'(head_q + PTR_W'(i))] == lookup_addr)) begin
            hit      = 1'b1;
            hit_data = data_q[PTR_W'(head_q + PTR_W'(i))];
         end
      end
   end

   assign head_idx  = addr_q[head_q][IDX_W-1:0];
   assign head_data = data_q[head_q];
   assign count     = count_q;

endmodule

// File: rtl/main_memory_ctrl.sv
// Main-memory back end: posted write-back buffer, read forwarding, fixed-latency store.
module main_memory_ctrl
   import mm_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned READ_LAT  = 4,
   parameter int unsigned WRITE_LAT = 2,
   parameter int unsigned WB_DEPTH  = 4
) (
   input  logic               clk,
   input  logic               rst,
   main_memory_ctrl_if.slave  bus
);

   localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
   localparam int unsigned BLK_W    = ADDR_W - BLK_OFF_W;
   localparam int unsigned WB_CNT_W = $clog2(WB_DEPTH) + 1;
   localparam int unsigned LAT_W    = $clog2(max_u(READ_LAT, WRITE_LAT));

   mm_state_t         state_q, state_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              mm_ready, accept, push, pop, read_done;
   logic              wb_hit;
   logic [DATA_W-1:0] wb_hit_data, head_data, mem_rdata;
   logic [IDX_W-1:0]  head_idx;
   logic [WB_CNT_W-1:0] wb_cnt;
   logic [BLK_W-1:0]  req_blk;
   logic              unused_offset;

   // Backing store survives rst; only its power-up contents are defined
   logic [DATA_W-1:0] mem [MEM_WORDS] = '{default: DATA_W'(MM_INIT_PATTERN)};

   assign req_blk       = bus.req_addr[ADDR_W-1:BLK_OFF_W];
   // Byte offset within the line plays no part in addressing
   assign unused_offset = ^bus.req_addr[BLK_OFF_W-1:0];

   wb_fifo #(
      .BLK_W  (BLK_W),
      .IDX_W  (IDX_W),
      .DATA_W (DATA_W),
      .DEPTH  (WB_DEPTH)
   ) u_wb_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_addr   (req_blk),
      .push_data   (bus.req_wdata),
      .pop         (pop),
      .head_idx    (head_idx),
      .head_data   (head_data),
      .count       (wb_cnt),
      .lookup_addr (req_blk),
      .hit         (wb_hit),
      .hit_data    (wb_hit_data)
   );

   assign mm_ready  = (state_q == StIdle) && (wb_cnt != WB_CNT_W'(WB_DEPTH));
   assign accept    = bus.req_valid && mm_ready;
   assign mem_rdata = mem[idx_q];
   assign read_done = (state_q == StRead) && (lat_q == '0);

   // Next-state logic: requests take priority over starting a drain
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      idx_d   = idx_q;
      rdata_d = rdata_q;
      push    = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (bus.req_write) begin
                  push = 1'b1;
               end else if (wb_hit) begin
                  rdata_d = wb_hit_data;
                  state_d = StFwd;
               end else begin
                  idx_d   = bus.req_addr[BLK_OFF_W +: IDX_W];
                  lat_d   = LAT_W'(READ_LAT - 1);
                  state_d = StRead;
               end
            end else if (wb_cnt != '0) begin
               lat_d   = LAT_W'(WRITE_LAT - 1);
               state_d = StDrain;
            end
         end
         StFwd: begin
            state_d = StIdle;
         end
         StRead: begin
            if (lat_q == '0) begin
               rdata_d = mem_rdata;
               state_d = StIdle;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
         StDrain: begin
            if (lat_q == '0) begin
               pop     = 1'b1;
               state_d = StIdle;
            end else begin
               lat_d = lat_q - 1'b1;
            end
         end
      endcase
   end

   // FSM, latency counter and response data registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         lat_q   <= '0;
         idx_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         idx_q   <= idx_d;
         rdata_q <= rdata_d;
      end
   end

   // Drain commit; a drain interrupted by rst never reaches the store
   always_ff @(posedge clk) begin
      if (pop && !rst) mem[head_idx] <= head_data;
   end

   assign bus.mm_ready   = mm_ready;
   assign bus.resp_valid = (state_q == StFwd) || read_done;
   assign bus.resp_rdata = read_done ? mem_rdata : rdata_q;
   assign bus.wb_count   = wb_cnt;
   assign bus.busy       = (state_q != StIdle) || (wb_cnt != '0);

endmodule
